// File: rtl/grid_pkg.sv
// Shared definitions for the life-grid display path: grid geometry, scan states
// and the row extraction helper.
package grid_pkg;

    localparam int GRID_W    = 64;
    localparam int GRID_ROWS = 8;
    localparam int GRID_COLS = 8;

    typedef enum logic [1:0] {
        SCAN_IDLE,
        SCAN_BLANK,
        SCAN_DRIVE
    } scan_state_t;

    // Row 0 occupies the most significant byte of the generation word.
    function automatic logic [GRID_COLS-1:0] row_of(input logic [GRID_W-1:0] g,
                                                    input logic [31:0]       r);
        row_of = g[GRID_W-1-GRID_COLS*r -: GRID_COLS];
    endfunction

endpackage

// File: rtl/grid_row_scanner_if.sv
// Valid/ready channel carrying one 64-bit generation from the evolution FSM
// to the display scanner.
interface grid_if;
    import grid_pkg::*;

    logic [GRID_W-1:0] grid;
    logic              grid_valid;
    logic              grid_ready;

    modport master (output grid, output grid_valid, input  grid_ready);
    modport slave  (input  grid, input  grid_valid, output grid_ready);
endinterface

// File: rtl/grid_row_scanner_scan_timer.sv
// Loadable saturating down-counter timing the blank and dwell phases of a row.
module scan_timer #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         tick_i,
    output logic [W-1:0] count_o,
    output logic         expired_o
);
    logic [W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (tick_i && (count_q != '0)) begin
            count_q <= count_q - W'(1);
        end
    end

    assign count_o   = count_q;
    assign expired_o = (count_q == '0);
endmodule

// File: rtl/grid_row_scanner.sv
// LED matrix row scanner: double-buffers incoming generations and scans the
// active frame one row at a time with blanking, swapping frames only at frame start.
module grid_row_scanner
    import grid_pkg::*;
#(
    parameter int ROWS      = GRID_ROWS,
    parameter int COLS      = GRID_COLS,
    parameter int DWELL     = 4,
    parameter int BLANK_CYC = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            enable,
    grid_if.slave           gin,
    output logic [ROWS-1:0] row_sel,
    output logic [COLS-1:0] col_data,
    output logic            frame_done
);
    localparam int CMAX = (DWELL > BLANK_CYC) ? DWELL : BLANK_CYC;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1;

    localparam logic [CW-1:0] BLANK_LD = CW'(BLANK_CYC - 1);
    localparam logic [CW-1:0] DWELL_LD = CW'(DWELL - 1);
    localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);

    scan_state_t       state_q;
    logic [RW-1:0]     row_idx_q;
    logic              pending_q;
    logic              have_frame_q;
    logic [GRID_W-1:0] shadow_q;
    logic [GRID_W-1:0] active_q;
    logic [ROWS-1:0]   row_sel_q;
    logic [COLS-1:0]   col_data_q;
    logic              frame_done_q;

    logic          accept;
    logic          start;
    logic          last_row;
    logic          tmr_load;
    logic          tmr_tick;
    logic [CW-1:0] tmr_val;
    logic [CW-1:0] tmr_count;
    logic          tmr_expired;

    assign gin.grid_ready = !pending_q;
    assign accept         = gin.grid_valid && !pending_q;
    assign start          = (state_q == SCAN_IDLE) && (pending_q || have_frame_q);
    assign last_row       = (row_idx_q == LAST_ROW);

    // The timer is reloaded on every state change and counts down while the state holds.
    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = '0;
        if (!enable) begin
            tmr_load = 1'b1;
        end else begin
            case (state_q)
                SCAN_IDLE:  if (start)       begin tmr_load = 1'b1; tmr_val = BLANK_LD; end
                SCAN_BLANK: if (tmr_expired) begin tmr_load = 1'b1; tmr_val = DWELL_LD; end
                SCAN_DRIVE: if (tmr_expired) begin tmr_load = 1'b1; tmr_val = BLANK_LD; end
                default:    tmr_load = 1'b1;
            endcase
        end
        tmr_tick = !tmr_load;
    end

    scan_timer #(.W(CW)) u_timer (
        .clk        (clk),
        .reset      (reset),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .tick_i     (tmr_tick),
        .count_o    (tmr_count),
        .expired_o  (tmr_expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= SCAN_IDLE;
            row_idx_q    <= '0;
            pending_q    <= 1'b0;
            have_frame_q <= 1'b0;
            shadow_q     <= '0;
            active_q     <= '0;
            row_sel_q    <= '0;
            col_data_q   <= '0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            if (accept) begin
                shadow_q  <= gin.grid;
                pending_q <= 1'b1;
            end
            if (!enable) begin
                state_q    <= SCAN_IDLE;
                row_idx_q  <= '0;
                row_sel_q  <= '0;
                col_data_q <= '0;
            end else begin
                case (state_q)
                    SCAN_IDLE: if (start) begin
                        state_q   <= SCAN_BLANK;
                        row_idx_q <= '0;
                        if (pending_q) begin
                            active_q     <= shadow_q;
                            pending_q    <= 1'b0;
                            have_frame_q <= 1'b1;
                        end
                    end
                    SCAN_BLANK: if (tmr_expired) begin
                        state_q      <= SCAN_DRIVE;
                        row_sel_q    <= ROWS'(1) << row_idx_q;
                        col_data_q   <= COLS'(row_of(active_q, 32'(row_idx_q)));
                        frame_done_q <= last_row && (DWELL == 1);
                    end
                    SCAN_DRIVE: if (tmr_expired) begin
                        state_q    <= SCAN_BLANK;
                        row_sel_q  <= '0;
                        col_data_q <= '0;
                        if (last_row) begin
                            row_idx_q <= '0;
                            if (pending_q) begin
                                active_q     <= shadow_q;
                                pending_q    <= 1'b0;
                                have_frame_q <= 1'b1;
                            end
                        end else begin
                            row_idx_q <= row_idx_q + RW'(1);
                        end
                    end else if (last_row && (tmr_count == CW'(1))) begin
                        // Registered pulse must be set one cycle ahead of the final dwell cycle.
                        frame_done_q <= 1'b1;
                    end
                    default: state_q <= SCAN_IDLE;
                endcase
            end
        end
    end

    assign row_sel    = row_sel_q;
    assign col_data   = col_data_q;
    assign frame_done = frame_done_q;
endmodule

// File: tb/tb_grid_row_scanner.sv
// Scoreboard bench for grid_row_scanner: a frame-position reference model queues the
// expected outputs per cycle and a negedge monitor compares them against the DUT.
module tb_grid_row_scanner;
    import grid_pkg::*;

    localparam int ROWS  = 8;
    localparam int DWELL = 4;
    localparam int BLK   = 1;
    localparam int PER   = BLK + DWELL;
    localparam int FRAME = ROWS * PER;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [7:0] row_sel;
    logic [7:0] col_data;
    logic       frame_done;

    grid_if gbus();

    grid_row_scanner #(.ROWS(ROWS), .COLS(8), .DWELL(DWELL), .BLANK_CYC(BLK)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .gin        (gbus),
        .row_sel    (row_sel),
        .col_data   (col_data),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] rs;
        logic [7:0] cd;
        logic       fd;
        logic       rdy;
    } exp_t;

    exp_t expq[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model: a frame is a position counter 0..FRAME-1; each row is BLK blank
    // cycles followed by DWELL lit cycles.
    bit          m_run, m_pend, m_have, m_acc;
    int          m_pos;
    logic [63:0] m_shadow, m_active;

    always @(posedge clk) begin
        exp_t e;
        bit   acc;
        int   r;
        m_acc = 1'b0;
        if (reset) begin
            m_run = 0; m_pend = 0; m_have = 0; m_pos = 0;
            m_shadow = '0; m_active = '0;
        end else begin
            acc = gbus.grid_valid && !m_pend;
            if (!enable) begin
                m_run = 0; m_pos = 0;
            end else if (!m_run) begin
                if (m_pend || m_have) begin
                    m_run = 1; m_pos = 0;
                    if (m_pend) begin m_active = m_shadow; m_pend = 0; m_have = 1; end
                end
            end else begin
                m_pos++;
                if (m_pos == FRAME) begin
                    m_pos = 0;
                    if (m_pend) begin m_active = m_shadow; m_pend = 0; m_have = 1; end
                end
            end
            if (acc) begin m_shadow = gbus.grid; m_pend = 1; m_acc = 1; end
        end
        e = '0;
        e.rdy = !m_pend;
        if (m_run && (m_pos % PER) >= BLK) begin
            r = m_pos / PER;
            e.rs = 8'(1) << r;
            e.cd = 8'(m_active >> (8 * (ROWS - 1 - r)));
            e.fd = (r == ROWS - 1) && ((m_pos % PER) == PER - 1);
        end
        expq.push_back(e);
    end

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (expq.size() > 0) begin
            e = expq.pop_front();
            chk("row_sel",    row_sel,                  e.rs);
            chk("col_data",   col_data,                 e.cd);
            chk("frame_done", {7'd0, frame_done},       {7'd0, e.fd});
            chk("grid_ready", {7'd0, gbus.grid_ready},  {7'd0, e.rdy});
        end
    end

    // Source side: holds grid/valid until the model sees the handshake.
    task automatic drive(input int cycles, input int p_new, input int p_en);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk); #1;
            if (m_acc) gbus.grid_valid = 1'b0;
            if (!gbus.grid_valid && p_new > 0 && $urandom_range(99) < p_new) begin
                gbus.grid = ($urandom_range(7) == 0) ? 64'd0 : {$urandom, $urandom};
                gbus.grid_valid = 1'b1;
            end
            if (p_en > 0 && $urandom_range(99) < p_en) enable = !enable;
        end
    endtask

    task automatic present(input logic [63:0] g);
        @(negedge clk); #1;
        if (m_acc) gbus.grid_valid = 1'b0;
        gbus.grid = g;
        gbus.grid_valid = 1'b1;
    endtask

    task automatic wait_row(input int row, input string nm);
        int i;
        for (i = 0; i < 400; i++) begin
            if (m_run && (m_pos / PER) == row && (m_pos % PER) >= BLK) break;
            drive(1, 0, 0);
        end
        n_tests++;
        if (i == 400) begin
            n_fail++;
            $display("FAIL %s: row %0d not reached within 400 cycles", nm, row);
        end
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0;
        gbus.grid = '0; gbus.grid_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1 reset = 1'b0;

        // No frame ever accepted: scanner stays idle.
        enable = 1'b1;
        drive(30, 0, 0);

        // First frame and its full scan.
        present(64'h0405060000000000);
        drive(100, 0, 0);

        // B mid-frame, then C while B is still pending.
        present(64'hFF00000000000000);
        drive(6, 0, 0);
        present(64'h00000000000000A5);
        drive(150, 0, 0);

        // Disable while row 3 is lit, then resume.
        wait_row(3, "wait_row3");
        enable = 1'b0;
        drive(3, 0, 0);
        enable = 1'b1;
        drive(60, 0, 0);

        // Reset during row 5 with a frame pending: that frame must never appear.
        wait_row(0, "wait_row0");
        present(64'h1122334455667788);
        wait_row(5, "wait_row5");
        reset = 1'b1;
        gbus.grid_valid = 1'b0;
        drive(2, 0, 0);
        reset = 1'b0;
        drive(60, 0, 0);

        // Randomised traffic with occasional enable toggles.
        drive(3000, 10, 1);
        enable = 1'b1;
        drive(200, 5, 0);

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
